// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, x0 constant and index-width helper for writeback sharing
package rf_wb_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO = 0;
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N = 3,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);
  logic found;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en_i && !found && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % N);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin share of the register file write port with a one-cycle write
// stage and read-after-write hazard flags against that stage
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_REQ = 3,
  parameter int GW = clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_stall,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  input  logic [ADDR_W-1:0]       src_one,
  input  logic [ADDR_W-1:0]       src_two,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       dest,
  output logic [XLEN-1:0]         data_in,
  output logic [GW-1:0]           grant_id,
  output logic                    hazard_one,
  output logic                    hazard_two
);
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, win;
  logic we_q, we_d, hs;
  logic [ADDR_W-1:0] dest_q, dest_d, win_dest;
  logic [XLEN-1:0] data_q, data_d;
  logic [GW-1:0] gid_q, gid_d;
  rr_arbiter #(.N(NUM_REQ), .PW(GW)) u_rr (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .en_i (!reset && !wb_stall),
    .gnt_o(req_ready),
    .idx_o(win)
  );
  assign hs = |req_ready;
  assign win_dest = req_dest[int'(win)*ADDR_W +: ADDR_W];
  always_comb begin
    we_d = hs && (win_dest != ADDR_W'(REG_ZERO));
    dest_d = hs ? win_dest : dest_q;
    data_d = hs ? req_data[int'(win)*XLEN +: XLEN] : data_q;
    gid_d = hs ? win : gid_q;
    rr_ptr_d = !hs ? rr_ptr_q : (win == GW'(NUM_REQ - 1)) ? '0 : win + GW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      gid_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      we_q <= we_d;
      dest_q <= dest_d;
      data_q <= data_d;
      gid_q <= gid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign write_enable = we_q;
  assign dest = dest_q;
  assign data_in = data_q;
  assign grant_id = gid_q;
  assign hazard_one = we_q && (dest_q == src_one) && (src_one != ADDR_W'(REG_ZERO));
  assign hazard_two = we_q && (dest_q == src_two) && (src_two != ADDR_W'(REG_ZERO));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus reset sequences for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam logic [31:0] A0 = 32'hA0A0_0000, A1 = 32'hA1A1_1111, A2 = 32'hA2A2_2222;
  localparam logic [31:0] B0 = 32'hB0B0_0000, B1 = 32'hB1B1_1111;
  logic clk = 1'b0, reset = 1'b1, wb_stall = 1'b0;
  logic [2:0] req_valid = '0, req_ready;
  logic [14:0] req_dest = '0;
  logic [95:0] req_data = '0;
  logic [4:0] src_one = '0, src_two = '0, dest;
  logic write_enable, hazard_one, hazard_two;
  logic [31:0] data_in;
  logic [1:0] grant_id;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset), .wb_stall(wb_stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data),
    .src_one(src_one), .src_two(src_two),
    .write_enable(write_enable), .dest(dest), .data_in(data_in),
    .grant_id(grant_id), .hazard_one(hazard_one), .hazard_two(hazard_two)
  );

  typedef struct {
    logic stall;
    logic [2:0] valid;
    logic [4:0] d0, d1, d2;
    logic [31:0] x0, x1, x2;
    logic [4:0] s1, s2;
    logic [2:0] rdy;
    logic h1, h2, we;
    logic [4:0] dst;
    logic [31:0] dat;
    logic [1:0] gid;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(logic st, logic [2:0] v, logic [4:0] d0, d1, d2,
                              logic [31:0] x0, x1, x2, logic [4:0] s1, s2,
                              logic [2:0] rdy, logic h1, h2, we,
                              logic [4:0] dst, logic [31:0] dat, logic [1:0] gid);
    vec_t r;
    r.stall = st; r.valid = v; r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.x0 = x0; r.x1 = x1; r.x2 = x2; r.s1 = s1; r.s2 = s2;
    r.rdy = rdy; r.h1 = h1; r.h2 = h2; r.we = we; r.dst = dst; r.dat = dat; r.gid = gid;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    wb_stall = t.stall;
    req_valid = t.valid;
    req_dest = {t.d2, t.d1, t.d0};
    req_data = {t.x2, t.x1, t.x0};
    src_one = t.s1;
    src_two = t.s2;
  endtask

  task automatic chk_stage(input string tag, input logic we, input logic [4:0] d,
                           input logic [31:0] x, input logic [1:0] g);
    chk({tag, ".write_enable"}, 32'(write_enable), 32'(we));
    chk({tag, ".dest"}, 32'(dest), 32'(d));
    chk({tag, ".data_in"}, data_in, x);
    chk({tag, ".grant_id"}, 32'(grant_id), 32'(g));
  endtask

  initial begin
    tv[0]  = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 3, 4, 3'b001, 0, 0, 1, 3, A0, 0);
    tv[1]  = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 3, 4, 3'b010, 1, 0, 1, 4, A1, 1);
    tv[2]  = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 4, 4, 3'b100, 1, 1, 1, 5, A2, 2);
    tv[3]  = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 0, 0, 3'b001, 0, 0, 1, 3, A0, 0);
    tv[4]  = mk(1, 3'b111, 3, 4, 5, A0, A1, A2, 3, 0, 3'b000, 1, 0, 0, 3, A0, 0);
    tv[5]  = mk(1, 3'b111, 3, 4, 5, A0, A1, A2, 3, 0, 3'b000, 0, 0, 0, 3, A0, 0);
    tv[6]  = mk(1, 3'b111, 3, 4, 5, A0, A1, A2, 3, 0, 3'b000, 0, 0, 0, 3, A0, 0);
    tv[7]  = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 0, 0, 3'b010, 0, 0, 1, 4, A1, 1);
    tv[8]  = mk(0, 3'b010, 3, 7, 5, A0, 32'hDEADBEEF, A2, 4, 0, 3'b010, 1, 0, 1, 7, 32'hDEADBEEF, 1);
    tv[9]  = mk(0, 3'b100, 3, 4, 0, A0, A1, 32'h1234, 7, 0, 3'b100, 1, 0, 0, 0, 32'h1234, 2);
    tv[10] = mk(0, 3'b111, 3, 4, 5, A0, A1, A2, 0, 0, 3'b001, 0, 0, 1, 3, A0, 0);
    tv[11] = mk(0, 3'b000, 3, 4, 5, A0, A1, A2, 3, 3, 3'b000, 1, 1, 0, 3, A0, 0);
    tv[12] = mk(0, 3'b001, 9, 4, 5, 32'h55, A1, A2, 9, 0, 3'b001, 0, 0, 1, 9, 32'h55, 0);
    tv[13] = mk(0, 3'b000, 9, 4, 5, 32'h55, A1, A2, 9, 10, 3'b000, 1, 0, 0, 9, 32'h55, 0);
    tv[14] = mk(0, 3'b010, 9, 0, 5, A0, 32'h77, A2, 0, 0, 3'b010, 0, 0, 0, 0, 32'h77, 1);
    tv[15] = mk(0, 3'b000, 9, 0, 5, A0, 32'h77, A2, 0, 0, 3'b000, 0, 0, 0, 0, 32'h77, 1);
    tv[16] = mk(0, 3'b011, 6, 6, 5, B0, B1, A2, 0, 0, 3'b001, 0, 0, 1, 6, B0, 0);
    tv[17] = mk(0, 3'b011, 6, 6, 5, B0, B1, A2, 6, 0, 3'b010, 1, 0, 1, 6, B1, 1);

    // Reset held two cycles with every requester valid
    @(negedge clk);
    reset = 1'b1;
    drive(tv[0]);
    for (int c = 0; c < 2; c++) begin
      #1 chk("rst.req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1 chk_stage("rst", 0, 0, 0, 0);
      @(negedge clk);
    end
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d.hazard_one", i), 32'(hazard_one), 32'(tv[i].h1));
      chk($sformatf("v%0d.hazard_two", i), 32'(hazard_two), 32'(tv[i].h2));
      @(posedge clk);
      #1 chk_stage($sformatf("v%0d", i), tv[i].we, tv[i].dst, tv[i].dat, tv[i].gid);
    end

    // Reset while a write sits in the stage drops it and rewinds the pointer
    @(negedge clk);
    drive(mk(0, 3'b001, 8, 4, 5, 32'hC0, A1, A2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("mid.req_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1 chk_stage("mid", 1, 8, 32'hC0, 0);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 3'b111;
    #1 chk("midrst.req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1 chk_stage("midrst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 3'b110;
    #1 chk("post.req_ready", 32'(req_ready), 32'b010);
    @(posedge clk);
    #1 chk_stage("post", 1, 4, A1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (dest / write_enable / data_in) between NUM_REQ writeback requesters, e.g. ALU result, load unit and CSR unit.
- Arbitrates round-robin over valid/ready handshakes and registers the winner into a one-cycle write stage that drives the register file.
- Reports read-after-write hazards for the two register file read sources while a write is in flight in that stage.

Parameters:
- XLEN, 32, data width of the register file.
- ADDR_W, 5, register index width.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- wb_stall  input  1  when high, no grant is issued this cycle.
- req_valid  input  NUM_REQ  requester i holds a write.
- req_ready  output  NUM_REQ  one-hot grant; a handshake on i occurs when valid[i] and ready[i] are both high.
- req_dest  input  NUM_REQ*ADDR_W  destination index of requester i, at slice i.
- req_data  input  NUM_REQ*XLEN  write data of requester i, at slice i.
- src_one  input  ADDR_W  read source 1 index for the hazard check.
- src_two  input  ADDR_W  read source 2 index for the hazard check.
- write_enable  output  1  register file write strobe (registered).
- dest  output  ADDR_W  register file write index (registered).
- data_in  output  XLEN  register file write data (registered).
- grant_id  output  clog2(NUM_REQ)  index of the last accepted requester (registered).
- hazard_one  output  1  src_one matches the in-flight write.
- hazard_two  output  1  src_two matches the in-flight write.

Behaviour:
- Reset values:
  - write_enable=0, dest=0, data_in=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 in every cycle where reset is high.
  - reset mid-transfer discards the staged write: write_enable is 0 on the next cycle.
- Grant (combinational, same cycle):
  - If reset=0, wb_stall=0 and any req_valid is set, exactly one req_ready bit goes high.
  - The winner is the first valid index searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - req_ready is never high for an invalid requester.
  - Otherwise req_ready=0.
- Registered write stage (updated every edge when not in reset):
  - On a handshake: dest<=winner dest, data_in<=winner data, grant_id<=winner, write_enable<=(winner dest != 0).
  - Without a handshake: write_enable<=0; dest, data_in and grant_id hold their values.
  - Latency is exactly 1 cycle, handshake to write_enable. The register file commits on the following edge.
  - Throughput is one write per cycle.
- Pointer update:
  - After a handshake, rr_ptr<=(winner+1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
  - x0 writes are accepted and advance the pointer, but never assert write_enable.
- Fairness: a requester that holds valid is granted within NUM_REQ cycles of non-stalled operation.
- Hazards (combinational):
  - hazard_one = write_enable && (dest==src_one) && (src_one!=0); hazard_two is the same for src_two.
  - They are never asserted for x0.
- Simultaneous events:
  - Stall plus valid: no grant, and the pointer is unchanged.
  - All requesters valid: grants rotate 0,1,2,0,…
  - Two requesters with the same dest in consecutive cycles: both are issued in grant order, so the last one granted wins in the register file.
- Requester obligations: a requester must hold dest/data stable while valid is high without ready. Violations are not protected against.

Decomposition:
- Shared package holds:
  - XLEN and ADDR_W defaults.
  - REG_ZERO constant (0).
  - clog2 helper for the grant index width.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Pure combinational; reused later for memory port sharing.
- Data muxing, the write stage and the hazard compare stay in rf_wb_arbiter.

Test Plan:
- Reset: hold reset 2 cycles with all valid=1 → req_ready=000, write_enable=0, dest=0, data_in=0. After release, first grant goes to requester 0.
- Single requester: valid=010, dest1=7, data1=0xDEADBEEF → ready=010 in cycle N. Cycle N+1: write_enable=1, dest=7, data_in=0xDEADBEEF, grant_id=1.
- Round-robin: all three valid for 4 cycles with dests 3/4/5 → grants 0,1,2,0. write_enable is high on 4 consecutive cycles with dests 3,4,5,3.
- x0 drop: requester 2 only, dest=0, data=0x1234 → ready=100, next cycle write_enable=0, rr_ptr advances to 0.
- Stall: all valid, wb_stall=1 for 3 cycles → ready=000, write_enable=0, pointer unchanged. After release, the grant goes to the pre-stall pointer.
- Hazard: stage a write to dest=9, then drive src_one=9, src_two=10 → hazard_one=1, hazard_two=0. A write to dest 0 with src_one=0 → hazard_one=0.
